// File: rtl/k6502_int_pkg.sv
// -----------------------------------------------------------------------------
// k6502_int_pkg
// Shared definitions for the 6502 interrupt controller: the service-state
// encoding and the fixed low bytes of the reset, NMI and IRQ/BRK vectors.
// -----------------------------------------------------------------------------
package k6502_int_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SVC_RST = 2'd1,
    SVC_NMI = 2'd2,
    SVC_IRQ = 2'd3
  } int_state_e;

  localparam logic [7:0] VEC_RST_LO = 8'hFC;
  localparam logic [7:0] VEC_NMI_LO = 8'hFA;
  localparam logic [7:0] VEC_IRQ_LO = 8'hFE;

endpackage : k6502_int_pkg

// File: rtl/in_sync.sv
// -----------------------------------------------------------------------------
// in_sync
// Multi-bit, multi-stage synchroniser for asynchronous active-low request
// lines. STAGES = 0 gives a plain wire (inputs already synchronous).
//
// Ports:
//   clk    in   core clock
//   rst_n  in   asynchronous active-low reset
//   i_d    in   [WIDTH]  asynchronous input
//   o_q    out  [WIDTH]  synchronised output
// -----------------------------------------------------------------------------
module in_sync #(
  parameter int WIDTH  = 1,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  generate
    if (STAGES == 0) begin : g_bypass
      assign o_q = i_d;
    end else begin : g_sync
      logic [WIDTH-1:0] r_chain [STAGES];

      // NOTE: flops reset to 1, the inactive level of an active-low request,
      // so leaving reset never looks like a falling edge downstream.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          for (int i = 0; i < STAGES; i++) r_chain[i] <= '1;
        end else begin
          r_chain[0] <= i_d;
          for (int i = 1; i < STAGES; i++) r_chain[i] <= r_chain[i-1];
        end
      end

      assign o_q = r_chain[STAGES-1];
    end
  endgenerate

endmodule : in_sync

// File: rtl/int_ctrl.sv
// -----------------------------------------------------------------------------
// int_ctrl
// Interrupt sequencer for the 6502 core. Arbitrates reset, edge-triggered NMI
// and N_IRQ level-triggered IRQ sources at instruction boundaries (sync), holds
// the chosen request stable until the microcode acknowledges it, and supplies
// the vector low byte to the data mux.
//
// Build option: define K6502_VECTORED_IRQ_EN to give each IRQ source its own
// vector (IRQ_VEC_BASE + 2*irq_id); otherwise all IRQs share 8'hFE.
//
// Ports:
//   clk       in   core clock
//   rst_n     in   asynchronous active-low reset
//   sync      in   opcode-fetch strobe (instruction boundary)
//   ack       in   interrupt sequence complete
//   i_flag    in   SR I bit, 1 masks IRQ
//   nmi_n     in   NMI request, active low, asynchronous
//   irq_n     in   [N_IRQ] IRQ requests, active low, level, asynchronous
//   irq_en    in   [N_IRQ] per-source enable
//   rst       out  servicing reset
//   nmi       out  servicing NMI
//   irq       out  servicing IRQ
//   irq_id    out  index of the serviced IRQ source
//   vec_lo    out  [8] vector low byte
//   pending   out  [N_IRQ] synchronised, enabled, asserted IRQ sources
//   nmi_pend  out  NMI edge latched
// -----------------------------------------------------------------------------
module int_ctrl
  import k6502_int_pkg::*;
#(
  parameter int N_IRQ       = 4,
  parameter int SYNC_STAGES = 2
`ifdef K6502_VECTORED_IRQ_EN
  ,
  parameter logic [7:0] IRQ_VEC_BASE = 8'hE0
`endif
) (
  input  logic                                         clk,
  input  logic                                         rst_n,
  input  logic                                         sync,
  input  logic                                         ack,
  input  logic                                         i_flag,
  input  logic                                         nmi_n,
  input  logic [N_IRQ-1:0]                             irq_n,
  input  logic [N_IRQ-1:0]                             irq_en,
  output logic                                         rst,
  output logic                                         nmi,
  output logic                                         irq,
  output logic [((N_IRQ > 1) ? $clog2(N_IRQ) : 1)-1:0] irq_id,
  output logic [7:0]                                   vec_lo,
  output logic [N_IRQ-1:0]                             pending,
  output logic                                         nmi_pend
);

  localparam int ID_W = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;

  logic             w_nmi_sync;
  logic [N_IRQ-1:0] w_irq_sync;
  logic [N_IRQ-1:0] w_pending;
  logic             w_nmi_edge;
  logic [ID_W-1:0]  w_pick;

  int_state_e       r_state;
  logic             r_nmi_prev;
  logic             r_nmi_latch;
  logic [ID_W-1:0]  r_irq_id;

  in_sync #(.WIDTH(1), .STAGES(SYNC_STAGES)) u_nmi_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (nmi_n),
    .o_q   (w_nmi_sync)
  );

  in_sync #(.WIDTH(N_IRQ), .STAGES(SYNC_STAGES)) u_irq_sync (
    .clk   (clk),
    .rst_n (rst_n),
    .i_d   (irq_n),
    .o_q   (w_irq_sync)
  );

  assign w_pending  = ~w_irq_sync & irq_en;
  assign w_nmi_edge = r_nmi_prev & ~w_nmi_sync;

  // Lowest set index wins: scan downwards so the last hit is the lowest.
  // NOTE: w_pick gets a default before the loop so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    w_pick = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (w_pending[i]) w_pick = ID_W'(i);
    end
  end

  // NOTE: all state is updated with non-blocking assignments so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= SVC_RST;
      r_nmi_prev  <= 1'b1;
      r_nmi_latch <= 1'b0;
      r_irq_id    <= '0;
    end else begin
      r_nmi_prev <= w_nmi_sync;

      // A fresh edge on the ack cycle must not be lost, so set beats clear.
      if (w_nmi_edge) begin
        r_nmi_latch <= 1'b1;
      end else if (r_state == SVC_NMI && ack) begin
        r_nmi_latch <= 1'b0;
      end

      case (r_state)
        IDLE: begin
          if (sync) begin
            if (r_nmi_latch) begin
              r_state <= SVC_NMI;
            end else if (!i_flag && |w_pending) begin
              r_state  <= SVC_IRQ;
              r_irq_id <= w_pick;
            end
          end
        end
        // In any service state the request is frozen until ack; sync is
        // ignored, and ack+sync returns to IDLE without re-arbitrating.
        default: begin
          if (ack) r_state <= IDLE;
        end
      endcase
    end
  end

  assign rst      = (r_state == SVC_RST);
  assign nmi      = (r_state == SVC_NMI);
  assign irq      = (r_state == SVC_IRQ);
  assign irq_id   = r_irq_id;
  assign pending  = w_pending;
  assign nmi_pend = r_nmi_latch;

  always_comb begin
    case (r_state)
      SVC_RST: vec_lo = VEC_RST_LO;
      SVC_NMI: vec_lo = VEC_NMI_LO;
`ifdef K6502_VECTORED_IRQ_EN
      SVC_IRQ: vec_lo = IRQ_VEC_BASE + {{(7 - ID_W){1'b0}}, r_irq_id, 1'b0};
`else
      SVC_IRQ: vec_lo = VEC_IRQ_LO;
`endif
      default: vec_lo = VEC_IRQ_LO;
    endcase
  end

endmodule : int_ctrl

// File: tb/tb_int_ctrl.sv
// -----------------------------------------------------------------------------
// tb_int_ctrl
// Self-checking bench for int_ctrl: directed scenarios with literal
// expectations, then randomized traffic compared every cycle against a
// behavioural model of the interrupt rules.
// -----------------------------------------------------------------------------
module tb_int_ctrl;

  localparam int N    = 4;
  localparam int SS   = 2;
  localparam int ID_W = 2;

  localparam int M_IDLE = 0;
  localparam int M_RST  = 1;
  localparam int M_NMI  = 2;
  localparam int M_IRQ  = 3;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            sync;
  logic            ack;
  logic            i_flag;
  logic            nmi_n;
  logic [N-1:0]    irq_n;
  logic [N-1:0]    irq_en;
  logic            rst;
  logic            nmi;
  logic            irq;
  logic [ID_W-1:0] irq_id;
  logic [7:0]      vec_lo;
  logic [N-1:0]    pending;
  logic            nmi_pend;

  int n_tests = 0;
  int n_fail  = 0;

  int_ctrl #(.N_IRQ(N), .SYNC_STAGES(SS)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .sync     (sync),
    .ack      (ack),
    .i_flag   (i_flag),
    .nmi_n    (nmi_n),
    .irq_n    (irq_n),
    .irq_en   (irq_en),
    .rst      (rst),
    .nmi      (nmi),
    .irq      (irq),
    .irq_id   (irq_id),
    .vec_lo   (vec_lo),
    .pending  (pending),
    .nmi_pend (nmi_pend)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Behavioural model. Raw input history is kept in queues (front = most
  // recent pre-edge sample); the synchronised view is the sample SS edges old.
  // ---------------------------------------------------------------------------
  int           m_state;
  bit           m_latch;
  bit           m_prev;
  int           m_id;
  logic         nhist[$];
  logic [N-1:0] ihist[$];

  function automatic logic nmi_seen();
    if (SS == 0) return nmi_n;
    return nhist[SS-1];
  endfunction

  function automatic logic [N-1:0] irq_seen();
    if (SS == 0) return irq_n;
    return ihist[SS-1];
  endfunction

  function automatic int lowest(input logic [N-1:0] v);
    for (int i = 0; i < N; i++) if (v[i]) return i;
    return 0;
  endfunction

  function automatic logic [7:0] exp_vec(input int st, input int id);
    case (st)
      M_RST: return 8'hFC;
      M_NMI: return 8'hFA;
`ifdef K6502_VECTORED_IRQ_EN
      M_IRQ: return 8'(8'hE0 + 2 * id);
`else
      M_IRQ: return 8'hFE;
`endif
      default: return 8'hFE;
    endcase
  endfunction

  task automatic model_reset();
    m_state = M_RST;
    m_latch = 1'b0;
    m_prev  = 1'b1;
    m_id    = 0;
    nhist.delete();
    ihist.delete();
    for (int i = 0; i < SS; i++) begin
      nhist.push_back(1'b1);
      ihist.push_back('1);
    end
  endtask

  task automatic model_step();
    logic         s_n;
    logic         fell;
    logic [N-1:0] pend;
    int           old_state;
    s_n       = nmi_seen();
    fell      = m_prev & ~s_n;
    m_prev    = s_n;
    pend      = ~irq_seen() & irq_en;
    old_state = m_state;
    if (m_state == M_IDLE) begin
      if (sync) begin
        if (m_latch) m_state = M_NMI;
        else if (!i_flag && pend != 0) begin
          m_state = M_IRQ;
          m_id    = lowest(pend);
        end
      end
    end else if (ack) begin
      m_state = M_IDLE;
    end
    if (fell) m_latch = 1'b1;
    else if (old_state == M_NMI && ack) m_latch = 1'b0;
    if (SS > 0) begin
      nhist.push_front(nmi_n);
      void'(nhist.pop_back());
      ihist.push_front(irq_n);
      void'(ihist.pop_back());
    end
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst_n);
      if (!rst_n) model_reset();
      else model_step();
    end
  end

  // Compare every output shortly after each active edge.
  initial begin
    forever begin
      @(posedge clk);
      #1;
      check("m_rst",      rst,      (m_state == M_RST));
      check("m_nmi",      nmi,      (m_state == M_NMI));
      check("m_irq",      irq,      (m_state == M_IRQ));
      check("m_irq_id",   irq_id,   m_id);
      check("m_vec_lo",   vec_lo,   exp_vec(m_state, m_id));
      check("m_pending",  pending,  ~irq_seen() & irq_en);
      check("m_nmi_pend", nmi_pend, m_latch);
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers: inputs change right after a falling edge.
  // ---------------------------------------------------------------------------
  task automatic pulse_sync();
    sync = 1'b1;
    @(negedge clk);
    sync = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
  endtask

  // One-cycle NMI low pulse, then wait until it is latched.
  task automatic nmi_pulse_and_latch();
    nmi_n = 1'b0;
    @(negedge clk);
    nmi_n = 1'b1;
    repeat (SS) @(negedge clk);
  endtask

  initial begin
    rst_n  = 1'b0;
    sync   = 1'b0;
    ack    = 1'b0;
    i_flag = 1'b1;
    nmi_n  = 1'b1;
    irq_n  = '1;
    irq_en = '1;

    // Reset state.
    repeat (3) @(negedge clk);
    check("reset_rst",      rst,      1);
    check("reset_vec",      vec_lo,   8'hFC);
    check("reset_pending",  pending,  0);
    check("reset_nmi_pend", nmi_pend, 0);
    check("reset_irq_id",   irq_id,   0);
    rst_n = 1'b1;
    pulse_sync();
    check("svc_rst_ignores_sync", rst, 1);
    pulse_ack();
    check("rst_ack_idle", rst,    0);
    check("idle_vec",     vec_lo, 8'hFE);

    // NMI edge latency: SS+1 edges from the fall.
    repeat (2) @(negedge clk);
    nmi_n = 1'b0;
    @(negedge clk);
    nmi_n = 1'b1;
    check("nmi_lat_e1", nmi_pend, 0);
    @(negedge clk);
    check("nmi_lat_e2", nmi_pend, 0);
    @(negedge clk);
    check("nmi_lat_e3", nmi_pend, 1);
    pulse_sync();
    check("nmi_taken",     nmi,      1);
    check("nmi_vec",       vec_lo,   8'hFA);
    pulse_ack();
    check("nmi_ack_idle",  nmi,      0);
    check("nmi_ack_clear", nmi_pend, 0);

    // Holding nmi_n low triggers once only.
    nmi_n = 1'b0;
    repeat (4) @(negedge clk);
    check("nmi_hold_latched", nmi_pend, 1);
    pulse_sync();
    pulse_ack();
    repeat (5) @(negedge clk);
    check("nmi_hold_no_retrig", nmi_pend, 0);
    nmi_n = 1'b1;
    repeat (4) @(negedge clk);

    // Asynchronous reset in the middle of SVC_NMI.
    nmi_pulse_and_latch();
    pulse_sync();
    check("pre_reset_nmi", nmi, 1);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_rst",      rst,      1);
    check("midrst_nmi",      nmi,      0);
    check("midrst_vec",      vec_lo,   8'hFC);
    check("midrst_nmi_pend", nmi_pend, 0);
    @(negedge clk);
    rst_n = 1'b1;
    pulse_ack();
    check("midrst_ack_idle", rst,    0);
    check("midrst_ack_vec",  vec_lo, 8'hFE);

    // IRQ priority: sources 1 and 3 asserted -> source 1.
    i_flag = 1'b0;
    irq_n  = 4'b0101;
    repeat (SS + 1) @(negedge clk);
    check("prio_pending", pending, 4'b1010);
    pulse_sync();
    check("prio_irq", irq,    1);
    check("prio_id",  irq_id, 1);
`ifdef K6502_VECTORED_IRQ_EN
    check("prio_vec", vec_lo, 8'hE2);
`else
    check("prio_vec", vec_lo, 8'hFE);
`endif
    irq_n = '1;
    repeat (SS + 1) @(negedge clk);
    pulse_sync();
    check("frozen_irq", irq,    1);
    check("frozen_id",  irq_id, 1);
    pulse_ack();
    check("irq_ack_idle", irq, 0);

    // Masking by i_flag and by irq_en.
    irq_n  = 4'b1101;
    i_flag = 1'b1;
    repeat (SS + 1) @(negedge clk);
    check("mask_pending", pending, 4'b0010);
    pulse_sync();
    check("mask_iflag_idle", irq, 0);
    i_flag = 1'b0;
    pulse_sync();
    check("unmask_irq", irq,    1);
    check("unmask_id",  irq_id, 1);
    pulse_ack();
    irq_en = 4'b1101;
    @(negedge clk);
    check("en_mask_pending", pending, 0);
    pulse_sync();
    check("en_mask_idle", irq, 0);
    irq_en = '1;

    // NMI beats a simultaneous IRQ; the IRQ is taken afterwards.
    irq_n = 4'b1011;
    nmi_pulse_and_latch();
    pulse_sync();
    check("nmi_over_irq_nmi", nmi, 1);
    check("nmi_over_irq_irq", irq, 0);
    pulse_ack();
    pulse_sync();
    check("after_nmi_irq", irq,    1);
    check("after_nmi_id",  irq_id, 2);
    pulse_ack();
    irq_n = '1;
    repeat (4) @(negedge clk);

    // New NMI edge on the same edge as ack+sync of SVC_NMI.
    nmi_pulse_and_latch();
    pulse_sync();
    check("corner_in_nmi", nmi, 1);
    nmi_n = 1'b0;
    @(negedge clk);
    nmi_n = 1'b1;
    @(negedge clk);
    ack  = 1'b1;
    sync = 1'b1;
    @(negedge clk);
    ack  = 1'b0;
    sync = 1'b0;
    check("corner_idle",     nmi,      0);
    check("corner_pend",     nmi_pend, 1);
    check("corner_vec",      vec_lo,   8'hFE);
    pulse_sync();
    check("corner_retaken",  nmi,      1);
    pulse_ack();
    check("corner_cleared",  nmi_pend, 0);

    // Randomized traffic checked by the model every cycle.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      sync   = ($urandom_range(0, 3) == 0);
      ack    = ($urandom_range(0, 3) == 0);
      i_flag = ($urandom_range(0, 2) == 0);
      if (nmi_n) nmi_n = ($urandom_range(0, 19) != 0);
      else       nmi_n = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 7) == 0)  irq_n  = N'($urandom);
      if ($urandom_range(0, 29) == 0) irq_en = N'($urandom);
      if (!rst_n) rst_n = 1'b1;
      else if ($urandom_range(0, 399) == 0) rst_n = 1'b0;
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule : tb_int_ctrl

// File: doc/int_ctrl.md
Name: int_ctrl

Overview:
- Parametrised successor to the single-source interrupt sequencer in the 6502 core.
- Arbitrates reset, edge-triggered NMI and N_IRQ level-triggered IRQ sources.
- Decisions are taken only at instruction boundaries (sync).
- Holds the selected service request stable for the microcode until acknowledged, and drives the vector low byte onto the data-mux "fi" input.

Parameters:
- N_IRQ, 4: number of IRQ sources (1..8); index 0 is highest priority.
- SYNC_STAGES, 2: synchroniser flops on nmi_n and irq_n (0 = bypass, max 3).
- IRQ_VEC_BASE, 8'hE0: low byte of the IRQ vector for source 0; used only with VECTORED_IRQ_EN.

Ports:
- clk  input  1  core clock.
- rst_n  input  1  asynchronous active-low reset.
- sync  input  1  opcode-fetch strobe from the instruction sequencer (next_sync).
- ack  input  1  microcode: interrupt sequence complete (vector high byte fetched).
- i_flag  input  1  SR I bit; 1 masks IRQ.
- nmi_n  input  1  NMI request, active low, asynchronous.
- irq_n  input  N_IRQ  IRQ requests, active low, level, asynchronous.
- irq_en  input  N_IRQ  per-source enable, 1 = enabled.
- rst  output  1  servicing reset.
- nmi  output  1  servicing NMI.
- irq  output  1  servicing IRQ.
- irq_id  output  max(1,$clog2(N_IRQ))  index of the serviced IRQ source.
- vec_lo  output  8  vector low byte.
- pending  output  N_IRQ  synchronised, enabled, asserted IRQ sources (combinational from registers).
- nmi_pend  output  1  NMI edge latched, not yet taken.

Behaviour:
- States: IDLE, SVC_RST, SVC_NMI, SVC_IRQ. Outputs rst/nmi/irq are a one-hot decode of state; all are 0 in IDLE.
- Reset (asynchronous, any time, including mid-service):
  - state=SVC_RST, nmi latch=0, edge-detect register=1.
  - Synchroniser flops =1; irq_id=0.
  - Hence rst=1, nmi=irq=0, vec_lo=8'hFC, pending=0.
- Synchroniser: nmi_n and each irq_n pass through SYNC_STAGES flops, reset to 1.
- NMI edge detect:
  - Latch sets on the clk edge where synchronised nmi_n=0 and previous=1.
  - Latency from an input fall to nmi_pend=1 is SYNC_STAGES+1 edges.
  - The latch clears on the edge that ends SVC_NMI (ack). A new edge detected on that same cycle wins: the latch stays 1.
- pending = ~irq_n_sync & irq_en. Level-sensitive, never latched.
- Arbitration, only on a clk edge with state==IDLE and sync==1:
  - nmi latch=1 -> SVC_NMI.
  - else if i_flag==0 and |pending -> SVC_IRQ, with irq_id = lowest set index of pending.
  - else stay IDLE.
- sync while not IDLE is ignored. The request is frozen: irq_id does not change even if pending changes or drops.
- ack in any SVC_* state -> IDLE on the next edge. ack in IDLE is ignored.
- ack and sync together in a SVC_* state -> IDLE; there is no re-arbitration on that edge. The next sync arbitrates.
- SVC_RST leaves only via ack. NMI edges arriving during SVC_RST are latched and taken at the first sync after ack.
- vec_lo: SVC_RST 8'hFC, SVC_NMI 8'hFA, SVC_IRQ 8'hFE, IDLE 8'hFE (BRK default).
- Interrupt response latency: the request is visible one edge after the arbitrating sync edge.

Optional Feature:
- Macro: K6502_VECTORED_IRQ_EN.
- Defined: in SVC_IRQ, vec_lo = IRQ_VEC_BASE + 2*irq_id (8-bit, wraps modulo 256).
- Undefined: vec_lo = 8'hFE for every IRQ source. irq_id is still reported. IRQ_VEC_BASE is unused.

Decomposition:
- Package k6502_int_pkg:
  - state encoding constants (IDLE/SVC_RST/SVC_NMI/SVC_IRQ);
  - vector constants VEC_RST_LO=8'hFC, VEC_NMI_LO=8'hFA, VEC_IRQ_LO=8'hFE.
- One sub-module: in_sync, a width- and stage-parametrised synchroniser with reset value 1. It is instantiated for nmi_n and irq_n.
- The priority encoder and FSM stay in int_ctrl.

Test Plan:
- Reset: pulse rst_n low mid-SVC_NMI -> immediately rst=1, nmi=0, vec_lo=FC, nmi_pend=0. Then ack -> IDLE, vec_lo=FE.
- NMI edge: SYNC_STAGES=2, drop nmi_n for 1 cycle -> nmi_pend=1 after 3 edges. Next sync -> nmi=1, vec_lo=FA. ack -> IDLE, nmi_pend=0. Holding nmi_n low does not retrigger.
- IRQ priority: irq_n=4'b0101 (sources 1, 3 asserted), irq_en=4'hF, i_flag=0, sync -> irq=1, irq_id=1. With K6502_VECTORED_IRQ_EN, vec_lo=E2.
- Masking: i_flag=1 with pending=4'b0010 -> sync keeps IDLE. Then i_flag=0, next sync -> SVC_IRQ; irq_en=4'b1101 on the same pending -> stays IDLE.
- NMI over IRQ: pending IRQ and latched NMI at the same sync -> SVC_NMI. After ack, next sync -> SVC_IRQ with the IRQ still asserted.
- Corner: new NMI edge on the same edge as the ack of SVC_NMI -> nmi_pend remains 1; ack+sync together -> IDLE, then the following sync -> SVC_NMI.
